// File: rtl/cmd_pkg.sv
// Shared definitions for the command link: FSM states and the 6-byte packet layout.
// The controller-side command decoder imports the same packet constants.
package cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int PKT_BYTES   = 6;
  localparam int POS_ADDR    = 0;
  localparam int POS_OP      = 1;
  localparam int POS_PAYLOAD = 2;

  // Byte at position pos of the packet: addr, opcode, then payload MSB first.
  function automatic logic [7:0] pkt_byte(input logic [7:0]  addr,
                                          input logic [7:0]  opcode,
                                          input logic [31:0] payload,
                                          input logic [2:0]  pos);
    case (pos)
      3'(POS_ADDR):        return addr;
      3'(POS_OP):          return opcode;
      3'(POS_PAYLOAD):     return payload[31:24];
      3'(POS_PAYLOAD + 1): return payload[23:16];
      3'(POS_PAYLOAD + 2): return payload[15:8];
      default:             return payload[7:0];
    endcase
  endfunction

endpackage

// File: rtl/cmd_timer.sv
// Clearable saturating idle timer. o_expired flags the increment that would
// bring the count to TIMEOUT-1, so the owner can register its timeout pulse.
module cmd_timer #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_expired
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] LAST    = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] PRE_END = TW'(TIMEOUT - 2);

  logic [TW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LAST)) begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_expired = i_inc && (r_count == PRE_END);

endmodule

// File: rtl/cmd_master.sv
// Host-side command initiator: sends a 6-byte command packet over the UART
// byte/busy handshake, then forwards a fixed-length response with an idle timeout.
module cmd_master
  import cmd_pkg::*;
#(
  parameter int RESP_BYTES = 15,
  parameter int TIMEOUT    = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic [7:0]  opcode,
  input  logic [31:0] payload,
  output logic        ready,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  resp_data,
  output logic        resp_valid,
  output logic [7:0]  resp_idx,
  output logic        done,
  output logic        timeout
);

  state_t      r_state;
  logic [2:0]  r_ptr;
  logic [7:0]  r_count;
  logic [7:0]  r_addr;
  logic [7:0]  r_op;
  logic [31:0] r_payload;
  logic        r_ready;
  logic [7:0]  r_tx_data;
  logic        r_tx_send;
  logic [7:0]  r_resp_data;
  logic        r_resp_valid;
  logic [7:0]  r_resp_idx;
  logic        r_done;
  logic        r_timeout;

  logic w_timer_clear;
  logic w_timer_inc;
  logic w_expired;

  assign w_timer_clear = (r_state != ST_RESP) || rx_valid;
  assign w_timer_inc   = (r_state == ST_RESP) && !rx_valid;

  cmd_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_timer_clear),
    .i_inc     (w_timer_inc),
    .o_expired (w_expired)
  );

  // NOTE: the command capture registers carry no reset; they are always
  // written on an accepted start before anything reads them.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && start) begin
      r_addr    <= addr;
      r_op      <= opcode;
      r_payload <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_count      <= '0;
      r_ready      <= 1'b1;
      r_tx_data    <= '0;
      r_tx_send    <= 1'b0;
      r_resp_data  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_idx   <= '0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_tx_send    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      case (r_state)
        ST_IDLE: if (start) begin
          r_ptr   <= '0;
          r_ready <= 1'b0;
          r_state <= ST_SEND;
        end
        ST_SEND: if (!tx_busy) begin
          r_tx_data <= pkt_byte(r_addr, r_op, r_payload, r_ptr);
          r_tx_send <= 1'b1;
          r_state   <= ST_GAP;
        end
        // One dead cycle lets the transmitter raise busy before it is sampled.
        ST_GAP: r_state <= ST_WAIT;
        ST_WAIT: if (!tx_busy) begin
          if (r_ptr == 3'(PKT_BYTES - 1)) begin
            r_count <= '0;
            r_state <= ST_RESP;
          end else begin
            r_ptr   <= r_ptr + 3'd1;
            r_state <= ST_SEND;
          end
        end
        ST_RESP: begin
          if (rx_valid) begin
            r_resp_data  <= rx_data;
            r_resp_idx   <= r_count;
            r_resp_valid <= 1'b1;
            r_count      <= r_count + 8'd1;
            if (r_count == 8'(RESP_BYTES - 1)) begin
              r_done  <= 1'b1;
              r_ready <= 1'b1;
              r_state <= ST_IDLE;
            end
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_ready   <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready      = r_ready;
  assign tx_data    = r_tx_data;
  assign tx_send    = r_tx_send;
  assign resp_data  = r_resp_data;
  assign resp_valid = r_resp_valid;
  assign resp_idx   = r_resp_idx;
  assign done       = r_done;
  assign timeout    = r_timeout;

endmodule

// File: tb/tb_cmd_master.sv
// Directed bench for cmd_master with a busy-after-send transmitter model;
// built with TIMEOUT=16 so the response timeout is reachable.
module tb_cmd_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  addr = '0;
  logic [7:0]  opcode = '0;
  logic [31:0] payload = '0;
  logic        tx_busy = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic [7:0]  resp_data;
  logic        resp_valid;
  logic [7:0]  resp_idx;
  logic        done;
  logic        timeout;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] txq[$];
  int         stray = 0;
  bit         expect_resp = 1'b0;
  int         busy_cnt = 0;

  cmd_master #(.RESP_BYTES(15), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .addr       (addr),
    .opcode     (opcode),
    .payload    (payload),
    .ready      (ready),
    .tx_data    (tx_data),
    .tx_send    (tx_send),
    .tx_busy    (tx_busy),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .resp_data  (resp_data),
    .resp_valid (resp_valid),
    .resp_idx   (resp_idx),
    .done       (done),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Transmitter model: busy rises one cycle after tx_send and stays up 10 cycles.
  always @(negedge clk) begin
    if (tx_send) txq.push_back(tx_data);
    if (resp_valid && !expect_resp) stray++;
    if (tx_send) busy_cnt = 11;
    else if (busy_cnt > 0) busy_cnt--;
    tx_busy = (busy_cnt > 0) && (busy_cnt <= 10);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},      32'(ready),      32'd1);
    check({tag, "_tx_send"},    32'(tx_send),    32'd0);
    check({tag, "_tx_data"},    32'(tx_data),    32'd0);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_data"},  32'(resp_data),  32'd0);
    check({tag, "_resp_idx"},   32'(resp_idx),   32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_timeout"},    32'(timeout),    32'd0);
  endtask

  task automatic issue(input logic [7:0] a, input logic [7:0] o, input logic [31:0] p);
    @(negedge clk);
    addr = a; opcode = o; payload = p; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_drop", 32'(ready), 32'd0);
  endtask

  task automatic wait_tx(input int n);
    int b = 0;
    while (txq.size() < n && b < 500) begin
      @(negedge clk);
      b++;
    end
    check("tx_count", 32'(txq.size()), 32'(n));
  endtask

  task automatic check_pkt(input string tag, input logic [47:0] exp);
    for (int i = 0; i < 6; i++) begin
      if (i < txq.size()) check(tag, 32'(txq[i]), 32'(exp[47 - 8*i -: 8]));
      else                check(tag, 32'hFFFF_FFFF, 32'(exp[47 - 8*i -: 8]));
    end
  endtask

  task automatic resp_byte(input logic [7:0] b, input int idx, input bit last);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("resp_data",  32'(resp_data),  32'(b));
    check("resp_idx",   32'(resp_idx),   32'(idx));
    check("resp_done",  32'(done),       32'(last));
    check("resp_no_to", 32'(timeout),    32'd0);
  endtask

  // Called at the negedge where the last resp_valid was seen.
  task automatic wait_timeout(input string tag);
    int k = 0;
    bit saw_done = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (done) saw_done = 1'b1;
    end while (!timeout && k < 40);
    check({tag, "_latency"}, 32'(k), 32'd15);
    check({tag, "_no_done"}, 32'(saw_done), 32'd0);
    @(negedge clk);
    check({tag, "_ready"},   32'(ready),   32'd1);
    check({tag, "_pulse"},   32'(timeout), 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;

    // Basic send + full response, with ignored start and stray rx mid-packet.
    issue(8'h12, 8'h02, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    addr = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rx_data = 8'h55; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_tx(6);
    repeat (12) @(negedge clk);
    check("ready_in_resp", 32'(ready), 32'd0);
    expect_resp = 1'b1;
    for (int i = 0; i < 15; i++) begin
      resp_byte(8'(i), i, i == 14);
      if (i < 14) repeat (3) @(negedge clk);
    end
    @(negedge clk);
    check("ready_after_done", 32'(ready), 32'd1);
    check("done_one_cycle",   32'(done),  32'd0);
    expect_resp = 1'b0;
    check("tx_sends_total", 32'(txq.size()), 32'd6);
    check_pkt("pkt_basic", 48'h1202_DEAD_BEEF);

    // Timeout after three bytes.
    txq.delete();
    issue(8'hA5, 8'h10, 32'h11223344);
    wait_tx(6);
    repeat (12) @(negedge clk);
    expect_resp = 1'b1;
    resp_byte(8'hA0, 0, 1'b0);
    repeat (3) @(negedge clk);
    resp_byte(8'hA1, 1, 1'b0);
    repeat (3) @(negedge clk);
    resp_byte(8'hA2, 2, 1'b0);
    wait_timeout("to_basic");
    expect_resp = 1'b0;

    // Byte arriving in the cycle the timer sits at 14 wins over expiry.
    txq.delete();
    issue(8'h3C, 8'h05, 32'h0BADF00D);
    wait_tx(6);
    check_pkt("pkt_edge", 48'h3C05_0BAD_F00D);
    repeat (12) @(negedge clk);
    expect_resp = 1'b1;
    resp_byte(8'hB0, 0, 1'b0);
    repeat (13) @(negedge clk);
    resp_byte(8'hB1, 1, 1'b0);
    wait_timeout("to_edge");
    expect_resp = 1'b0;

    // Reset during the third byte's WAIT, then a fresh command.
    txq.delete();
    issue(8'h34, 8'h07, 32'hCAFEF00D);
    wait_tx(3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset("rst_mid");
    txq.delete();
    issue(8'h77, 8'h03, 32'h01020304);
    wait_tx(6);
    check_pkt("pkt_after_rst", 48'h7703_0102_0304);
    begin
      int b = 0;
      bit saw_to = 1'b0;
      while (!saw_to && b < 80) begin
        @(negedge clk);
        b++;
        if (timeout) saw_to = 1'b1;
      end
      check("to_after_rst", 32'(saw_to), 32'd1);
    end

    check("stray_resp", 32'(stray), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
